delay_chain_meter: RTL and testbench
====================================

Name: delay_chain_meter

Overview:
Synchronous measurement stage that sits around a chain of one-unit async delay cells.
- Upstream: drives the chain input with a 2-phase launch toggle.
- Downstream: consumes the chain output, synchronizes it, and counts clk cycles until the edge returns.
- Repeats 2^RUNS_LOG2 launches per start and accumulates the counts, so firmware can calibrate unit-delay chains across PVT.

Parameters:
CNT_W, 16, width of the per-run cycle counter.
RUNS_LOG2, 3, log2 of launches per measurement (8 runs).
SYNC_STAGES, 2, flops in the ret_i synchronizer (min 2).
TIMEOUT, 1023, max cycles waited in ARM or WAIT before abort (< 2^CNT_W).

Ports:
clk  input  1  single clock.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a measurement; honoured only in IDLE.
launch_o  output  1  2-phase launch level driving the chain inR.
chain_en  output  1  drives the chain's active-low rst gate; high = chain enabled.
ret_i  input  1  chain outR; asynchronous to clk.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when a measurement ends (normal or abort).
timeout_err  output  1  sticky abort flag; cleared on the next accepted start.
last_cycles  output  CNT_W  count captured on the most recent completed run.
accum  output  CNT_W+RUNS_LOG2  sum of the run counts of the current/last measurement.
run_idx  output  RUNS_LOG2  index of the run in progress / last run.

Behaviour:
- Reset values (all outputs): 0. This includes launch_o=0 and chain_en=0. chain_en is a register set to 1 on the first cycle after rst falls.
- ret_s: ret_i after SYNC_STAGES flops. Synchronizer flops reset to 0.
- FSM states: IDLE, ARM, LAUNCH, WAIT, RECORD.
- IDLE:
  - start=1 -> ARM.
  - On that same edge: accum<=0, run_idx<=0, timeout_err<=0, cnt<=0.
- ARM:
  - Waits for ret_s==launch_o (chain quiescent).
  - On match -> LAUNCH, cnt<=0.
  - Otherwise cnt++. If cnt reaches TIMEOUT -> abort.
- LAUNCH: one cycle; launch_o<=~launch_o, cnt<=0 -> WAIT.
- WAIT:
  - If ret_s!=launch_o: cnt++. If cnt reaches TIMEOUT -> abort.
  - If ret_s==launch_o: last_cycles<=cnt, accum<=accum+cnt -> RECORD.
- RECORD:
  - If run_idx==2^RUNS_LOG2-1: done<=1 -> IDLE.
  - Else: run_idx++, cnt<=0 -> ARM.
- Abort: timeout_err<=1, done pulse, -> IDLE.
  - accum keeps the partial sum; last_cycles is unchanged.
  - launch_o keeps its current level. The next ARM re-checks quiescence.
- Latency definition: pure-wire loopback (ret_i=launch_o) gives last_cycles=SYNC_STAGES. An added chain delay of D clk cycles gives SYNC_STAGES+D.
- start while busy: ignored, with no effect on the sequence.
- accum cannot overflow: the width covers 2^RUNS_LOG2 * (2^CNT_W-1).
- rst mid-operation: everything returns to reset values the next edge, and chain_en=0 forces the chain output to 0. After release, the first ARM sees ret_s==launch_o==0.
- done and timeout_err are never both newly set except on abort, where both assert on the same edge.

Optional Feature:
DCM_SYNC_COMP_EN
- Defined: the captured run count is max(cnt-SYNC_STAGES, 0) before it is written to last_cycles and added to accum, so a wire loopback reads 0.
- Undefined: raw cnt is used, per the latency definition above.
- FSM, timing and all other behaviour are identical in both builds.

Decomposition:
- Package delay_meter_pkg:
  - state enum (IDLE, ARM, LAUNCH, WAIT, RECORD);
  - default CNT_W, RUNS_LOG2 and SYNC_STAGES constants;
  - accum width function.
- Sub-module sync_bit: parameterized N-stage synchronizer with synchronous active-high reset to 0, used for ret_i.
- FSM, counter and accumulator stay in delay_chain_meter.

Test Plan:
- Wire loopback, SYNC_STAGES=2, start pulse -> 8 runs, each last_cycles=2; accum=16; done pulses once; busy falls on the same edge; timeout_err=0.
- Behavioural chain, ret_i = launch_o delayed 3 clk -> last_cycles=5, accum=40, run_idx=7 at done.
- ret_i tied 0 -> first run aborts after TIMEOUT cycles in WAIT; timeout_err=1, done pulse, accum=0. A new start clears timeout_err.
- start held high for the whole measurement, plus a second start pulse mid-run -> exactly one measurement, one done pulse, accum=16 (loopback).
- rst asserted in WAIT of run 3 -> next edge all outputs 0, including chain_en. A start after release completes normally with accum=16.
- With DCM_SYNC_COMP_EN: loopback gives last_cycles=0 and accum=0; the 3-cycle chain gives last_cycles=3 and accum=24.

Source files
------------

// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: FSM states, default sizing and accumulator width for delay_chain_meter.
package delay_meter_pkg;
   typedef enum logic [2:0] {IDLE, ARM, LAUNCH, WAIT, RECORD} state_t;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_RUNS_LOG2 = 3;
   localparam int DEF_SYNC_STAGES = 2;
   function automatic int accum_w(input int cnt_w, input int runs_log2);
      return cnt_w + runs_log2;
   endfunction
endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_bit #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [N-1:0] s;
   always_ff @(posedge clk)
      if (rst) s <= '0;
      else s <= {s[N-2:0], d};
   assign q = s[N-1];
endmodule

// File: rtl/delay_chain_meter.sv
// delay_chain_meter: launches 2-phase edges into a delay chain, times each return and accumulates runs.
// Define DCM_SYNC_COMP_EN to subtract the synchronizer latency from each captured run count.
module delay_chain_meter
   import delay_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int RUNS_LOG2 = DEF_RUNS_LOG2,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT = 1023
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   output logic                                  launch_o,
   output logic                                  chain_en,
   input  logic                                  ret_i,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  timeout_err,
   output logic [CNT_W-1:0]                      last_cycles,
   output logic [accum_w(CNT_W, RUNS_LOG2)-1:0]  accum,
   output logic [RUNS_LOG2-1:0]                  run_idx
);
   localparam int AW = accum_w(CNT_W, RUNS_LOG2);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SS = CNT_W'(SYNC_STAGES);
   state_t state;
   logic [CNT_W-1:0] cnt, cap;
   logic ret_s;
   sync_bit #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(ret_i), .q(ret_s));
`ifdef DCM_SYNC_COMP_EN
   assign cap = cnt > SS ? cnt - SS : '0;
`else
   assign cap = cnt;
`endif
   assign busy = state != IDLE;
   // cnt == TO_LAST means this cycle's increment would reach TIMEOUT
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         launch_o <= 1'b0;
         chain_en <= 1'b0;
         done <= 1'b0;
         timeout_err <= 1'b0;
         last_cycles <= '0;
         accum <= '0;
         run_idx <= '0;
      end else begin
         chain_en <= 1'b1;
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  state <= ARM;
                  accum <= '0;
                  run_idx <= '0;
                  timeout_err <= 1'b0;
                  cnt <= '0;
               end
            ARM:
               if (ret_s == launch_o) begin
                  state <= LAUNCH;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == TO_LAST) begin
                     timeout_err <= 1'b1;
                     done <= 1'b1;
                     state <= IDLE;
                  end
               end
            LAUNCH: begin
               launch_o <= ~launch_o;
               cnt <= '0;
               state <= WAIT;
            end
            WAIT:
               if (ret_s != launch_o) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == TO_LAST) begin
                     timeout_err <= 1'b1;
                     done <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  last_cycles <= cap;
                  accum <= accum + AW'(cap);
                  state <= RECORD;
               end
            RECORD:
               if (&run_idx) begin
                  done <= 1'b1;
                  state <= IDLE;
               end else begin
                  run_idx <= run_idx + RUNS_LOG2'(1);
                  cnt <= '0;
                  state <= ARM;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_delay_chain_meter.sv
// tb_delay_chain_meter: randomized scoreboard bench with a behavioural delay chain around delay_chain_meter.
module tb_delay_chain_meter;
   localparam int CW = 16, RL = 3, SS = 2, TO = 1023, AW = CW + RL, NR = 1 << RL;
   typedef struct {int last; int acc; int idx; int terr; int cyc;} res_t;
   logic clk = 0, rst = 1, start = 0;
   logic ret_i, launch_o, chain_en, busy, done, timeout_err;
   logic [CW-1:0] last_cycles;
   logic [AW-1:0] accum;
   logic [RL-1:0] run_idx;
   int checks = 0, failures = 0, done_cnt = 0, exp_done = 0, model_last = 0, dly = 0;
   bit tie0 = 0;
   res_t exp_q[$];
   int run_q[$];
   logic [7:0] pipe;
   logic [8:0] taps;
   always #5 clk = ~clk;
   delay_chain_meter #(.CNT_W(CW), .RUNS_LOG2(RL), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .launch_o(launch_o), .chain_en(chain_en),
      .ret_i(ret_i), .busy(busy), .done(done), .timeout_err(timeout_err),
      .last_cycles(last_cycles), .accum(accum), .run_idx(run_idx)
   );
   // chain model: dly whole clk cycles of delay, output held low while the chain is disabled
   always @(posedge clk) pipe <= chain_en ? {pipe[6:0], launch_o} : 8'd0;
   assign taps = {pipe, launch_o};
   assign ret_i = chain_en & ~tie0 & taps[dly];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   function automatic int comp(input int raw);
`ifdef DCM_SYNC_COMP_EN
      return raw > SS ? raw - SS : 0;
`else
      return raw;
`endif
   endfunction
   int busy_cyc = 0;
   logic prev_busy = 0;
   logic [RL-1:0] prev_idx = '0;
   res_t r;
   always @(negedge clk) begin
      if (busy) busy_cyc = prev_busy ? busy_cyc + 1 : 1;
      if (busy && run_idx != prev_idx && run_idx != 0) begin
         if (run_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL run_unexpected run_idx=%0d", run_idx);
         end else chk("run_last_cycles", 64'(last_cycles), 64'(run_q.pop_front()));
      end
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected accum=%0d", accum);
         end else begin
            r = exp_q.pop_front();
            chk("done_last_cycles", 64'(last_cycles), 64'(r.last));
            chk("done_accum", 64'(accum), 64'(r.acc));
            chk("done_run_idx", 64'(run_idx), 64'(r.idx));
            chk("done_timeout_err", 64'(timeout_err), 64'(r.terr));
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_busy_cycles", 64'(busy_cyc), 64'(r.cyc));
         end
      end
      prev_busy = busy;
      prev_idx = run_idx;
   end
   // each run: ARM 1 + LAUNCH 1 + WAIT (raw+1) + RECORD 1 cycles
   task automatic expect_meas(input int d);
      int v = comp(SS + d);
      repeat (NR - 1) run_q.push_back(v);
      exp_q.push_back('{v, NR * v, NR - 1, 0, NR * (SS + d + 4)});
      model_last = v;
   endtask
   task automatic run(input bit hold, input bit noise, input bit chk_clr);
      int n = 0;
      repeat (8 + $urandom_range(0, 4)) @(negedge clk);
      start = 1;
      exp_done++;
      @(negedge clk);
      if (chk_clr) begin
         chk("start_clears_err", 64'(timeout_err), 64'd0);
         chk("busy_after_start", 64'(busy), 64'd1);
      end
      while (!done && n < 20000) begin
         start = hold | (noise & busy & ($urandom_range(0, 7) == 0));
         @(negedge clk);
         n++;
      end
      start = 0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL wait_done timed out after %0d cycles", n);
      end
   endtask
   task automatic chk_zero();
      chk("rst_launch_o", 64'(launch_o), 64'd0);
      chk("rst_chain_en", 64'(chain_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
      chk("rst_last_cycles", 64'(last_cycles), 64'd0);
      chk("rst_accum", 64'(accum), 64'd0);
      chk("rst_run_idx", 64'(run_idx), 64'd0);
   endtask
   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk_zero();
      rst = 0;
      @(negedge clk);
      chk("chain_en_after_rst", 64'(chain_en), 64'd1);
      dly = 0; expect_meas(0); run(0, 0, 0);
      dly = 3; expect_meas(3); run(0, 0, 0);
      tie0 = 1;
      exp_q.push_back('{model_last, 0, 0, 1, TO + 2});
      run(0, 0, 0);
      tie0 = 0; dly = 0;
      expect_meas(0); run(0, 0, 1);
      expect_meas(0); run(1, 0, 0);
      expect_meas(0); run(0, 1, 0);
      // reset in the WAIT state of run 3
      dly = 3; expect_meas(3);
      repeat (10) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (run_idx != 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (run_idx != 3) begin
         checks++; failures++;
         $display("FAIL reach_run3 timed out run_idx=%0d", run_idx);
      end
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk_zero();
      exp_q.delete();
      run_q.delete();
      model_last = 0;
      rst = 0;
      @(negedge clk);
      chk("chain_en_after_rel", 64'(chain_en), 64'd1);
      dly = 0; expect_meas(0); run(0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         dly = $urandom_range(0, 6);
         expect_meas(dly);
         run($urandom_range(0, 1) == 1, 1, 0);
      end
      repeat (4) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("run_q_drained", 64'(run_q.size()), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(exp_done));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
